// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions: response codes, interconnect FSM states, region width.
package ahb_pkg;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Width of the address field that selects a slave region.
    localparam int REGION_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ERR1,
        ERR2
    } ahb_ic_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: produces the two-cycle AHB ERROR response (ERR1 stalls, ERR2 completes).
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,    // an error response must begin next cycle
    input  logic advance,  // interconnect is in an error phase; step the sequence
    output logic ready,
    output logic resp
);

    ahb_ic_state_t phase;

    // Step IDLE -> ERR1 -> ERR2 -> IDLE; a new start re-enters ERR1 directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= IDLE;
        end else if (start) begin
            phase <= ERR1;
        end else if (advance) begin
            phase <= (phase == ERR1) ? ERR2 : IDLE;
        end else begin
            phase <= IDLE;
        end
    end

    assign ready = (phase != ERR1);
    assign resp  = (phase == ERR1 || phase == ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-lite interconnect: region decode, registered data-phase select,
// default ERROR slave, and per-slave wait-state timeout with quarantine.
module ahb_lite_interconnect
    import ahb_pkg::*;
#(
    parameter int NSLAVE     = 4,
    parameter int DW         = 32,
    parameter int REGION_LSB = 28,
    parameter int TIMEOUT    = 255
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HREQUEST,
    input  logic [31:0]          HADDR,
    input  logic                 HWRITE,
    input  logic [DW-1:0]        HWDATA,
    output logic [DW-1:0]        HRDATA,
    output logic                 HREADY,
    output logic                 HRESP,
    output logic [NSLAVE-1:0]    HSEL_S,
    output logic [31:0]          HADDR_S,
    output logic                 HWRITE_S,
    output logic [DW-1:0]        HWDATA_S,
    output logic                 HREADY_S,
    input  logic [NSLAVE*DW-1:0] HRDATA_S,
    input  logic [NSLAVE-1:0]    HREADYOUT_S,
    input  logic [NSLAVE-1:0]    HRESP_S
);

    localparam int SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    ahb_ic_state_t          state;
    ahb_ic_state_t          state_nxt;
    logic [SW-1:0]          sel_q;
    logic [CW-1:0]          wait_cnt;
    logic [NSLAVE-1:0]      quarantine;

    logic [REGION_BITS-1:0] region;
    logic [NSLAVE-1:0]      hit_oh;
    logic                   hit;
    logic [NSLAVE-1:0]      sel_oh;
    logic                   slave_ready;
    logic                   slave_resp;
    logic [DW-1:0]          slave_rdata;
    logic                   dflt_ready;
    logic                   dflt_resp;
    logic                   hready_int;
    logic                   accept;
    logic                   timeout_fire;
    logic [NSLAVE-1:0]      busy_oh;

    assign region = HADDR[REGION_LSB +: REGION_BITS];

    // Address decode: the region's slave is selected unless out of range or quarantined.
    always_comb begin
        hit_oh = '0;
        hit    = 1'b0;
        for (int unsigned i = 0; i < NSLAVE; i++) begin
            if (region == REGION_BITS'(i) && !quarantine[i]) begin
                hit_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    // Data-phase mux driven by the registered slave index.
    always_comb begin
        sel_oh      = '0;
        slave_ready = 1'b0;
        slave_resp  = HRESP_OKAY;
        slave_rdata = '0;
        for (int unsigned i = 0; i < NSLAVE; i++) begin
            if (sel_q == SW'(i)) begin
                sel_oh[i]   = 1'b1;
                slave_ready = HREADYOUT_S[i];
                slave_resp  = HRESP_S[i];
                slave_rdata = HRDATA_S[i*DW +: DW];
            end
        end
    end

    // Master-facing response depends on which phase owns the bus.
    always_comb begin
        hready_int = 1'b1;
        HRESP      = HRESP_OKAY;
        HRDATA     = '0;
        case (state)
            DATA: begin
                hready_int = slave_ready;
                HRESP      = slave_resp;
                HRDATA     = slave_rdata;
            end
            ERR1, ERR2: begin
                hready_int = dflt_ready;
                HRESP      = dflt_resp;
            end
            default: ;
        endcase
    end

    assign accept       = HREQUEST && hready_int;
    // A ready arriving on the last allowed wait cycle wins over the timeout.
    assign timeout_fire = (TIMEOUT != 0) && (state == DATA) && !slave_ready && (wait_cnt == TO_LAST);
    assign busy_oh      = (state == DATA) ? sel_oh : '0;

    // Next state: a completing cycle hands straight over to the newly accepted transfer.
    always_comb begin
        state_nxt = state;
        if (hready_int) begin
            if (accept) begin
                state_nxt = hit ? DATA : ERR1;
            end else begin
                state_nxt = IDLE;
            end
        end else if (timeout_fire) begin
            state_nxt = ERR1;
        end else if (state == ERR1) begin
            state_nxt = ERR2;
        end
    end

    // State, selected slave, wait counter and quarantine registers.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state      <= IDLE;
            sel_q      <= '0;
            wait_cnt   <= '0;
            quarantine <= '0;
        end else begin
            state <= state_nxt;
            if (accept && hit) begin
                sel_q <= region[SW-1:0];
            end
            wait_cnt   <= (state == DATA && !slave_ready && !timeout_fire) ? wait_cnt + 1'b1 : '0;
            quarantine <= (quarantine & ~(HREADYOUT_S & ~busy_oh)) | (timeout_fire ? sel_oh : '0);
        end
    end

    ahb_default_slave u_default_slave (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .start   ((accept && !hit) || timeout_fire),
        .advance ((state == ERR1) || (state == ERR2)),
        .ready   (dflt_ready),
        .resp    (dflt_resp)
    );

    assign HREADY   = hready_int;
    assign HREADY_S = hready_int;
    assign HSEL_S   = (HRESETn && HREQUEST) ? hit_oh : '0;
    assign HADDR_S  = HADDR;
    assign HWRITE_S = HWRITE;
    assign HWDATA_S = HWDATA;

endmodule

// File: doc/ahb_lite_interconnect.md
Name: ahb_lite_interconnect

Overview:
- Parametrised single-master, NSLAVE-slave AHB-lite interconnect.
- Successor to the fixed one-memory decoder/mux wrapper between the pipelined core's bus interface and dmem/peripherals.
- Adds:
  - region decode over N slaves;
  - registered data-phase mux;
  - a two-cycle ERROR default slave;
  - a per-slave wait-state timeout with quarantine.

Parameters:
- NSLAVE, 4, number of slave ports (1..16).
- DW, 32, data width.
- REGION_LSB, 28, region index = HADDR[REGION_LSB+3:REGION_LSB].
- TIMEOUT, 255, max consecutive wait cycles before error; 0 disables the timeout.

Ports:
- HCLK in 1: clock.
- HRESETn in 1: synchronous active-low reset.
- HREQUEST in 1: master transfer request (address phase valid).
- HADDR in 32: master address.
- HWRITE in 1: master write.
- HWDATA in DW: master write data (data phase).
- HRDATA out DW: read data to master.
- HREADY out 1: transfer complete / bus ready to master.
- HRESP out 1: 0 = OKAY, 1 = ERROR.
- HSEL_S out NSLAVE: one-hot slave select (address phase).
- HADDR_S out 32: address fanout.
- HWRITE_S out 1: write fanout.
- HWDATA_S out DW: write-data fanout.
- HREADY_S out 1: HREADY broadcast to slaves.
- HRDATA_S in NSLAVE*DW: slave read data, slave i at [i*DW +: DW].
- HREADYOUT_S in NSLAVE: per-slave ready.
- HRESP_S in NSLAVE: per-slave response.

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is synchronous, active-low, sampled on HCLK rising edge.
- Reset values:
  - state = IDLE;
  - sel_q = 0;
  - wait_cnt = 0;
  - quarantine = 0;
  - HREADY = 1, HRESP = 0, HRDATA = 0;
  - HSEL_S = 0, since HREQUEST is ignored during reset.
- Address phase:
  - Accepted when HREQUEST & HREADY.
  - region r = HADDR[REGION_LSB+3:REGION_LSB].
  - If r < NSLAVE and quarantine[r] = 0: HSEL_S[r] = 1 (combinational). Otherwise no HSEL_S bit is set, and the default slave is targeted.
  - HADDR_S, HWRITE_S and HWDATA_S are pure fanout, 0 latency.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE: HREADY = 1, HRESP = 0. An accepted valid-slave transfer goes to DATA (sel_q <= r). An accepted default-slave transfer goes to ERR1.
  - DATA: HREADY = HREADYOUT_S[sel_q], HRESP = HRESP_S[sel_q], HRDATA = HRDATA_S[sel_q].
    - On HREADY = 1 the transfer completes. The next state comes from any address phase accepted in that same cycle (DATA/ERR1), else IDLE. Back-to-back pipelining has 0 bubble cycles.
  - ERR1: HREADY = 0, HRESP = 1. Next state: ERR2.
  - ERR2: HREADY = 1, HRESP = 1. Next state: IDLE, or DATA/ERR1 if a new transfer is accepted.
  - HRDATA = 0 in IDLE, ERR1 and ERR2.
- Timeout:
  - In DATA, wait_cnt increments each cycle HREADYOUT_S[sel_q] = 0, and clears when it is 1 or on leaving DATA.
  - If TIMEOUT != 0 and wait_cnt == TIMEOUT-1 with the slave still not ready:
    - next state = ERR1;
    - set quarantine[sel_q];
    - the master sees a standard two-cycle ERROR. Total stall = TIMEOUT + 1 cycles before ERR2.
- Quarantine:
  - quarantine[i] clears on any cycle with HREADYOUT_S[i] = 1 while state != DATA or sel_q != i.
  - A late completion from a quarantined slave is discarded.
- Width: wait_cnt width = $clog2(TIMEOUT+1), minimum 1 bit. sel_q width = $clog2(NSLAVE), minimum 1 bit.
- Simultaneous events:
  - A timeout and a slave's ready arriving in the same cycle count as a completion; no error is raised.
  - Reset asserted mid-transfer returns the block to the reset values next edge and drops the data phase.

Decomposition:
- Shared package ahb_pkg:
  - HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  - typedef enum ahb_ic_state_t {IDLE, DATA, ERR1, ERR2};
  - REGION_BITS = 4.
- Sub-module ahb_default_slave: owns the ERR1/ERR2 sequencing. Inputs are start and advance; outputs are its HREADY/HRESP contribution.
- Decode, mux, timeout and quarantine logic stay in the top module.

Test Plan:
- Read 0x1000_0004, slave1 ready immediately with HRDATA_S1 = 0xDEADBEEF → HSEL_S = 4'b0010 in the address cycle; next cycle HRDATA = 0xDEADBEEF, HREADY = 1, HRESP = 0.
- Back-to-back write to 0x0000_0000 then read of 0x2000_0000, both zero-wait → HSEL_S 0001 then 0100 on consecutive cycles; no idle cycle between data phases.
- Access 0x5000_0000 with NSLAVE = 4 → no HSEL_S bit set; HREADY/HRESP = 0/1 then 1/1; state returns to IDLE.
- Slave2 holds HREADYOUT low, TIMEOUT = 8 → 8 wait cycles, then ERR1, ERR2; quarantine[2] = 1. A following access to 0x2000_0000 gets ERROR without HSEL_S[2]. Once slave2 raises ready, quarantine[2] clears and the next access selects it.
- Slave0 inserts 3 wait states then HRESP_S0 = 1 → HREADY low for 3 cycles; HRESP forwarded, unmodified.
- HRESETn = 0 during a slave3 data phase with 2 waits elapsed → next edge: HREADY = 1, HRESP = 0, HRDATA = 0, wait_cnt = 0, quarantine = 0.
